// File: rtl/miriscv_lsu.sv
// miriscv_lsu -- load/store unit between the core and a gnt/rvalid data bus.
//
// Accepts one access at a time from the core, checks size and alignment,
// issues a single bus request, waits for the grant (and for rvalid on loads),
// and then spends one DONE cycle reporting the completion or fault. The core
// is stalled while the access is in flight. A cycle counter aborts the access
// if the bus does not answer within TIMEOUT cycles.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   lsu_req_i, lsu_we_i     core request, 1 = store / 0 = load
//   lsu_size_i              B=0 H=1 W=2 BU=4 HU=5
//   lsu_addr_i, lsu_data_i  byte address, store data
//   lsu_data_o              extended load result, held until the next load
//   lsu_stall_req_o         core stall request
//   lsu_fault_o, lsu_fault_cause_o  abort flag and cause (01 misaligned,
//                           10 illegal size, 11 timeout), valid in DONE only
//   data_req_o .. data_wdata_o      memory-side request
//   data_gnt_i, data_rvalid_i, data_rdata_i  memory-side response
module miriscv_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_fault_o,
  output logic [1:0]  lsu_fault_cause_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state, nextState;
  logic        weQ;
  logic [2:0]  sizeQ;
  logic [31:0] addrQ;
  logic [31:0] dataQ;
  logic [1:0]  causeQ;
  logic [7:0]  cnt;
  logic [1:0]  reqCause;
  logic        timeoutHit;

  // Select the addressed byte/halfword of the bus word and extend it.
  // BU/HU share the low two size bits with B/H; size[2] marks zero-extension.
  function automatic logic [31:0] extendLoad(input logic [2:0]  size,
                                             input logic [1:0]  off,
                                             input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] byteEnable(input logic [2:0] size,
                                            input logic [1:0] off);
    case (size[1:0])
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated across lanes so the byte enables pick the lane.
  function automatic logic [31:0] storeData(input logic [2:0]  size,
                                            input logic [31:0] data);
    case (size[1:0])
      2'd0:    return {4{data[7:0]}};
      2'd1:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Illegal size wins over misalignment.
  always_comb begin
    reqCause = 2'b00;
    if (!(lsu_size_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
      reqCause = 2'b10;
    else if (lsu_size_i[1:0] == 2'd1 && lsu_addr_i[0])
      reqCause = 2'b01;
    else if (lsu_size_i == 3'd2 && lsu_addr_i[1:0] != 2'b00)
      reqCause = 2'b01;
  end

  assign timeoutHit = (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState       = state;
    lsu_stall_req_o = 1'b0;
    data_req_o      = 1'b0;
    data_be_o       = 4'b0000;
    case (state)
      IDLE: begin
        lsu_stall_req_o = lsu_req_i;
        if (lsu_req_i) nextState = (reqCause != 2'b00) ? DONE : REQ;
      end
      REQ: begin
        lsu_stall_req_o = 1'b1;
        data_req_o      = 1'b1;
        data_be_o       = byteEnable(sizeQ, addrQ[1:0]);
        if (data_gnt_i)      nextState = weQ ? DONE : RESP;
        else if (timeoutHit) nextState = DONE;
      end
      RESP: begin
        lsu_stall_req_o = 1'b1;
        if (data_rvalid_i || timeoutHit) nextState = DONE;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Captured request, cycle counter, fault cause and load result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      weQ        <= 1'b0;
      sizeQ      <= 3'd0;
      addrQ      <= 32'd0;
      dataQ      <= 32'd0;
      causeQ     <= 2'b00;
      cnt        <= 8'd0;
      lsu_data_o <= 32'd0;
    end else begin
      case (state)
        IDLE: if (lsu_req_i) begin
          weQ    <= lsu_we_i;
          sizeQ  <= lsu_size_i;
          addrQ  <= lsu_addr_i;
          dataQ  <= lsu_data_i;
          causeQ <= reqCause;
          cnt    <= 8'd0;
        end
        REQ: begin
          if (data_gnt_i)      cnt    <= 8'd0;
          else if (timeoutHit) causeQ <= 2'b11;
          else                 cnt    <= cnt + 8'd1;
        end
        RESP: begin
          if (data_rvalid_i)   lsu_data_o <= extendLoad(sizeQ, addrQ[1:0], data_rdata_i);
          else if (timeoutHit) causeQ     <= 2'b11;
          else                 cnt        <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign data_addr_o       = {addrQ[31:2], 2'b00};
  assign data_we_o         = weQ;
  assign data_wdata_o      = storeData(sizeQ, dataQ);
  assign lsu_fault_o       = (state == DONE) && (causeQ != 2'b00);
  assign lsu_fault_cause_o = (state == DONE) ? causeQ : 2'b00;

endmodule

// File: tb/tb_miriscv_lsu.sv
module tb_miriscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o, lsu_fault_o;
  logic [1:0]  lsu_fault_cause_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_gnt_i, data_rvalid_i;
  logic [31:0] data_rdata_i;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastLoad = 32'd0;
  int          reqCycles;

  miriscv_lsu #(.TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_data_o(lsu_data_o), .lsu_stall_req_o(lsu_stall_req_o),
    .lsu_fault_o(lsu_fault_o), .lsu_fault_cause_o(lsu_fault_cause_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic issue(input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] data);
    cyc();
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size;
    lsu_addr_i = addr; lsu_data_i = data;
    #1 chk("issue_stall", lsu_stall_req_o, 1);
  endtask

  // Wait (bounded) for the DONE cycle, then pop and compare the scoreboard.
  task automatic waitDone(input string tag);
    exp_t e;
    int   n = 0;
    while (lsu_stall_req_o && n < 40) begin
      cyc(); #1; n++;
    end
    chk({tag, "_done"}, lsu_stall_req_o, 0);
    if (sbq.size() == 0) begin
      chk({tag, "_sbq"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_data"}, lsu_data_o, e.data);
      chk({tag, "_fault"}, lsu_fault_o, e.fault);
      chk({tag, "_cause"}, lsu_fault_cause_o, e.cause);
    end
  endtask

  task automatic doLoad(input string tag, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] rdata, input logic [3:0] expBe,
                        input logic [31:0] expData);
    issue(1'b0, size, addr, 32'd0);
    sbq.push_back('{data: expData, fault: 1'b0, cause: 2'b00});
    lastLoad = expData;
    cyc(); lsu_req_i = 1'b0; data_gnt_i = 1'b1;
    #1 chk({tag, "_req"}, data_req_o, 1);
    chk({tag, "_be"}, data_be_o, expBe);
    chk({tag, "_addr"}, data_addr_o, {addr[31:2], 2'b00});
    chk({tag, "_stall_req"}, lsu_stall_req_o, 1);
    cyc(); data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = rdata;
    #1 chk({tag, "_stall_resp"}, lsu_stall_req_o, 1);
    chk({tag, "_be_resp"}, data_be_o, 0);
    cyc(); data_rvalid_i = 1'b0; data_rdata_i = 32'hA5A5A5A5;
    #1 waitDone(tag);
  endtask

  task automatic doStore(input string tag, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] expBe,
                         input logic [31:0] expWdata, input int waits);
    issue(1'b1, size, addr, data);
    sbq.push_back('{data: lastLoad, fault: 1'b0, cause: 2'b00});
    for (int i = 0; i < waits; i++) begin
      cyc(); lsu_req_i = 1'b0; data_gnt_i = 1'b0;
      #1 chk({tag, "_wait_req"}, data_req_o, 1);
    end
    cyc(); lsu_req_i = 1'b0; data_gnt_i = 1'b1;
    #1 chk({tag, "_req"}, data_req_o, 1);
    chk({tag, "_be"}, data_be_o, expBe);
    chk({tag, "_wdata"}, data_wdata_o, expWdata);
    chk({tag, "_addr"}, data_addr_o, {addr[31:2], 2'b00});
    chk({tag, "_we"}, data_we_o, 1);
    cyc(); data_gnt_i = 1'b0;
    #1 waitDone(tag);
  endtask

  task automatic doFault(input string tag, input logic [2:0] size,
                         input logic [31:0] addr, input logic [1:0] cause);
    issue(1'b0, size, addr, 32'd0);
    sbq.push_back('{data: lastLoad, fault: 1'b1, cause: cause});
    cyc(); lsu_req_i = 1'b0;
    #1 chk({tag, "_noreq"}, data_req_o, 0);
    waitDone(tag);
    cyc(); #1 chk({tag, "_clr"}, {lsu_fault_o, lsu_fault_cause_o}, 0);
  endtask

  initial begin
    rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0;
    lsu_addr_i = 32'd0; lsu_data_i = 32'd0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
    cyc(); cyc();
    #1 chk("rst_data", lsu_data_o, 0);
    chk("rst_stall", lsu_stall_req_o, 0);
    chk("rst_fault", {lsu_fault_o, lsu_fault_cause_o}, 0);
    chk("rst_req", data_req_o, 0);
    chk("rst_be", data_be_o, 0);
    chk("rst_addr", data_addr_o, 0);
    cyc(); rst_i = 1'b0;

    doLoad("lb_1003", 3'd0, 32'h0000_1003, 32'h80123456, 4'b1000, 32'hFFFFFF80);
    doStore("sh_2002", 3'd1, 32'h0000_2002, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 2);
    doFault("lw_mis", 3'd2, 32'h0000_0001, 2'b01);
    doFault("lh_mis", 3'd1, 32'h0000_0003, 2'b01);
    doFault("size3", 3'd3, 32'h0000_0000, 2'b10);
    doFault("size7", 3'd7, 32'h0000_0001, 2'b10);
    doLoad("lhu_0006", 3'd5, 32'h0000_0006, 32'h80011234, 4'b1100, 32'h00008001);
    doLoad("lh_0006", 3'd1, 32'h0000_0006, 32'h80011234, 4'b1100, 32'hFFFF8001);
    doLoad("lbu_1001", 3'd4, 32'h0000_1001, 32'h0000F700, 4'b0010, 32'h000000F7);
    doLoad("lw_0040", 3'd2, 32'h0000_0040, 32'h12345678, 4'b1111, 32'h12345678);
    doStore("sb_0005", 3'd0, 32'h0000_0005, 32'h000000AB, 4'b0010, 32'hABABABAB, 0);
    doStore("sw_0008", 3'd2, 32'h0000_0008, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1);

    // Grant never comes: bus request held for TIMEOUT cycles, then abort.
    issue(1'b0, 3'd2, 32'h0000_0010, 32'd0);
    sbq.push_back('{data: lastLoad, fault: 1'b1, cause: 2'b11});
    cyc(); lsu_req_i = 1'b0; #1;
    reqCycles = 0;
    while (data_req_o && reqCycles < 40) begin
      reqCycles++; cyc(); #1;
    end
    chk("timeout_cycles", reqCycles, 16);
    waitDone("timeout");

    // Reset in the middle of a load, then a stray rvalid.
    issue(1'b0, 3'd2, 32'h0000_0020, 32'd0);
    cyc(); lsu_req_i = 1'b0; data_gnt_i = 1'b1;
    cyc(); data_gnt_i = 1'b0; rst_i = 1'b1;
    #1 chk("midrst_data", lsu_data_o, 0);
    chk("midrst_stall", lsu_stall_req_o, 0);
    chk("midrst_req", data_req_o, 0);
    chk("midrst_addr", data_addr_o, 0);
    chk("midrst_fault", {lsu_fault_o, lsu_fault_cause_o}, 0);
    cyc(); rst_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hDEADBEEF;
    cyc(); data_rvalid_i = 1'b0;
    #1 chk("late_rvalid_data", lsu_data_o, 0);
    chk("late_rvalid_stall", lsu_stall_req_o, 0);

    doLoad("lb_after_rst", 3'd0, 32'h0000_0002, 32'h007F0000, 4'b0100, 32'h0000007F);
    chk("sbq_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
